// File: rtl/guess_round_ctrl.sv
// -----------------------------------------------------------------------------
// guess_round_ctrl
//
// Round controller for the number-guessing game. It sits directly downstream
// of the countdown timer: it consumes the timer's counter value and drives the
// timer's active-low restart input. A round is started with a one-cycle start
// pulse. Guesses are then scored against the latched secret and higher/lower
// hints are issued. The round ends in WIN on a correct guess, or in LOSE on
// timeout or when the tries are exhausted.
//
// Parameters
//   VAL_W      width of secret, guess and timer count (default 7)
//   MAX_TRIES  guesses allowed per round, 1..15 (default 10)
//
// Ports
//   clk            in   1      system clock, all state on posedge
//   rst_n          in   1      asynchronous active-low reset
//   start          in   1      begin new round (accepted in IDLE/WIN/LOSE)
//   Max_digit      in   2      difficulty 1/2/3, 0 = invalid (start ignored)
//   secret         in   VAL_W  target value, sampled on accepted start
//   guess          in   VAL_W  player guess
//   guess_valid    in   1      one-cycle strobe qualifying guess
//   timer_count    in   VAL_W  counter output of the countdown timer
//   timer_restart  out  1      0 = hold timer cleared, 1 = run (ARM/PLAY)
//   hint_hi        out  1      last scored guess < secret
//   hint_lo        out  1      last scored guess > secret
//   win            out  1      round won, held until next start
//   lose           out  1      round lost, held until next start
//   tries_used     out  4      guesses counted this round
//   time_left      out  VAL_W  timer_count captured on the winning guess
//   busy           out  1      high in ARM or PLAY
//   bad_guess      out  1      (GUESS_RANGE_CHECK_EN only) one-cycle pulse
//                              for a guess above the difficulty's range
//
// Build option
//   GUESS_RANGE_CHECK_EN : when defined, guesses above the range limit of the
//   latched difficulty (9 / 99 / 127) are not scored and pulse bad_guess.
//   When undefined, bad_guess is absent and every guess in PLAY is scored.
// -----------------------------------------------------------------------------
module guess_round_ctrl #(
  parameter int unsigned VAL_W     = 7,
  parameter int unsigned MAX_TRIES = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       Max_digit,
  input  logic [VAL_W-1:0] secret,
  input  logic [VAL_W-1:0] guess,
  input  logic             guess_valid,
  input  logic [VAL_W-1:0] timer_count,
  output logic             timer_restart,
  output logic             hint_hi,
  output logic             hint_lo,
  output logic             win,
  output logic             lose,
  output logic [3:0]       tries_used,
  output logic [VAL_W-1:0] time_left,
  output logic             busy
`ifdef GUESS_RANGE_CHECK_EN
  ,
  output logic             bad_guess
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_PLAY,
    ST_WIN,
    ST_LOSE
  } state_t;

  localparam logic [3:0] C_MAX_TRIES = 4'(MAX_TRIES);

  state_t           r_state;
  state_t           w_state_nxt;

  logic [VAL_W-1:0] r_secret;
  logic [3:0]       r_tries;
  logic             r_hint_hi;
  logic             r_hint_lo;
  logic             r_win;
  logic             r_lose;
  logic [VAL_W-1:0] r_time_left;

  logic [VAL_W-1:0] w_secret_nxt;
  logic [3:0]       w_tries_nxt;
  logic             w_hint_hi_nxt;
  logic             w_hint_lo_nxt;
  logic             w_win_nxt;
  logic             w_lose_nxt;
  logic [VAL_W-1:0] w_time_left_nxt;

  logic             w_start_ok;
  logic             w_in_range;
  logic             w_scored;
  logic             w_correct;
  logic             w_last_try;
  logic             w_timeout;
  logic [3:0]       w_tries_inc;

`ifdef GUESS_RANGE_CHECK_EN
  logic [1:0]       r_diff;
  logic [1:0]       w_diff_nxt;
  logic             r_bad_guess;
  logic             w_bad_guess_nxt;
  logic [VAL_W-1:0] w_limit;

  // Range limit follows the difficulty latched at round start, not the live
  // Max_digit input.
  always_comb begin
    w_limit = VAL_W'(127);
    case (r_diff)
      2'd1:    w_limit = VAL_W'(9);
      2'd2:    w_limit = VAL_W'(99);
      default: w_limit = VAL_W'(127);
    endcase
  end

  assign w_in_range = (guess <= w_limit);
`else
  assign w_in_range = 1'b1;
`endif

  assign w_start_ok  = start && (Max_digit != 2'd0);
  assign w_scored    = guess_valid && w_in_range;
  assign w_correct   = w_scored && (guess == r_secret);
  assign w_timeout   = (timer_count == '0);
  // 4-bit compare; MAX_TRIES is limited to 1..15 so this never needs carry-out
  assign w_last_try  = ((r_tries + 4'd1) == C_MAX_TRIES);
  assign w_tries_inc = (r_tries == C_MAX_TRIES) ? r_tries : (r_tries + 4'd1);

  // ---------------------------------------------------------------------------
  // State register and round data
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_secret    <= '0;
      r_tries     <= '0;
      r_hint_hi   <= 1'b0;
      r_hint_lo   <= 1'b0;
      r_win       <= 1'b0;
      r_lose      <= 1'b0;
      r_time_left <= '0;
`ifdef GUESS_RANGE_CHECK_EN
      r_diff      <= '0;
      r_bad_guess <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_secret    <= w_secret_nxt;
      r_tries     <= w_tries_nxt;
      r_hint_hi   <= w_hint_hi_nxt;
      r_hint_lo   <= w_hint_lo_nxt;
      r_win       <= w_win_nxt;
      r_lose      <= w_lose_nxt;
      r_time_left <= w_time_left_nxt;
`ifdef GUESS_RANGE_CHECK_EN
      r_diff      <= w_diff_nxt;
      r_bad_guess <= w_bad_guess_nxt;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and next-data logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt     = r_state;
    w_secret_nxt    = r_secret;
    w_tries_nxt     = r_tries;
    w_hint_hi_nxt   = r_hint_hi;
    w_hint_lo_nxt   = r_hint_lo;
    w_win_nxt       = r_win;
    w_lose_nxt      = r_lose;
    w_time_left_nxt = r_time_left;
`ifdef GUESS_RANGE_CHECK_EN
    w_diff_nxt      = r_diff;
    w_bad_guess_nxt = 1'b0;
`endif

    case (r_state)
      ST_IDLE, ST_WIN, ST_LOSE: begin
        // guess_valid is ignored here; results stay stable until a new round
        if (w_start_ok) begin
          w_state_nxt     = ST_ARM;
          w_secret_nxt    = secret;
          w_tries_nxt     = '0;
          w_hint_hi_nxt   = 1'b0;
          w_hint_lo_nxt   = 1'b0;
          w_win_nxt       = 1'b0;
          w_lose_nxt      = 1'b0;
          w_time_left_nxt = '0;
`ifdef GUESS_RANGE_CHECK_EN
          w_diff_nxt      = Max_digit;
`endif
        end
      end

      ST_ARM: begin
        // The timer reads 0 while held and for one cycle after release, so
        // play only begins once it shows a non-zero count.
        if (!w_timeout) begin
          w_state_nxt = ST_PLAY;
        end
      end

      ST_PLAY: begin
`ifdef GUESS_RANGE_CHECK_EN
        w_bad_guess_nxt = guess_valid && !w_in_range;
`endif
        if (w_correct) begin
          // A correct guess beats a simultaneous timeout.
          w_state_nxt     = ST_WIN;
          w_tries_nxt     = w_tries_inc;
          w_win_nxt       = 1'b1;
          w_hint_hi_nxt   = 1'b0;
          w_hint_lo_nxt   = 1'b0;
          w_time_left_nxt = timer_count;
        end else begin
          if (w_scored) begin
            w_tries_nxt   = w_tries_inc;
            w_hint_hi_nxt = (guess < r_secret);
            w_hint_lo_nxt = (guess > r_secret);
          end
          // Leaving PLAY on the first zero drops timer_restart, so the
          // timer's wrap past 0 is never seen.
          if ((w_scored && w_last_try) || w_timeout) begin
            w_state_nxt = ST_LOSE;
            w_lose_nxt  = 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Decoded straight from the state register so that an asynchronous reset
  // drops timer_restart in the same cycle.
  assign timer_restart = (r_state == ST_ARM) || (r_state == ST_PLAY);
  assign busy          = timer_restart;
  assign hint_hi       = r_hint_hi;
  assign hint_lo       = r_hint_lo;
  assign win           = r_win;
  assign lose          = r_lose;
  assign tries_used    = r_tries;
  assign time_left     = r_time_left;
`ifdef GUESS_RANGE_CHECK_EN
  assign bad_guess     = r_bad_guess;
`endif

endmodule

// File: tb/tb_guess_round_ctrl.sv
// -----------------------------------------------------------------------------
// tb_guess_round_ctrl
//
// Directed and randomized bench for guess_round_ctrl. A simple countdown timer
// model drives timer_count from the DUT's timer_restart. Expected outputs come
// from a round-level reference model that is updated once per clock.
// -----------------------------------------------------------------------------
module tb_guess_round_ctrl;

  localparam int MAX_T = 10;
`ifdef GUESS_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [1:0] Max_digit;
  logic [6:0] secret;
  logic [6:0] guess;
  logic       guess_valid;
  logic [6:0] timer_count;
  logic       timer_restart;
  logic       hint_hi;
  logic       hint_lo;
  logic       win;
  logic       lose;
  logic [3:0] tries_used;
  logic [6:0] time_left;
  logic       busy;
`ifdef GUESS_RANGE_CHECK_EN
  logic       bad_guess;
`endif

  guess_round_ctrl #(.VAL_W(7), .MAX_TRIES(MAX_T)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .Max_digit     (Max_digit),
    .secret        (secret),
    .guess         (guess),
    .guess_valid   (guess_valid),
    .timer_count   (timer_count),
    .timer_restart (timer_restart),
    .hint_hi       (hint_hi),
    .hint_lo       (hint_lo),
    .win           (win),
    .lose          (lose),
    .tries_used    (tries_used),
    .time_left     (time_left),
    .busy          (busy)
`ifdef GUESS_RANGE_CHECK_EN
    ,
    .bad_guess     (bad_guess)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Countdown timer: cleared while restart is low, reads 0 for one cycle
  // after release, then loads tm_load and counts down (wrapping).
  logic [6:0] tcnt;
  logic       tarm;
  logic [6:0] tm_load;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt <= 7'd0;
      tarm <= 1'b1;
    end else if (!timer_restart) begin
      tcnt <= 7'd0;
      tarm <= 1'b1;
    end else if (tarm) begin
      tarm <= 1'b0;
      tcnt <= tm_load;
    end else begin
      tcnt <= tcnt - 7'd1;
    end
  end
  assign timer_count = tcnt;

  int errors = 0;
  int checks = 0;

  // Reference model. running: 0 = no round, 1 = waiting for timer, 2 = playing
  int running;
  int m_sec, m_md, m_tries, m_tl;
  bit m_hi, m_lo, m_win, m_lose, m_bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic mdl_reset();
    running = 0;
    m_sec = 0; m_md = 0; m_tries = 0; m_tl = 0;
    m_hi = 0; m_lo = 0; m_win = 0; m_lose = 0; m_bad = 0;
  endtask

  function automatic int range_limit(input int md);
    if (md == 1) return 9;
    if (md == 2) return 99;
    return 127;
  endfunction

  // One clock of round rules, evaluated on the values present before the edge.
  task automatic mdl_clock(input bit st, input int md, input int sec,
                           input bit gv, input int g, input int tc);
    bit counted;
    m_bad = 0;
    if (running == 0) begin
      if (st && md != 0) begin
        running = 1;
        m_sec = sec; m_md = md; m_tries = 0; m_tl = 0;
        m_hi = 0; m_lo = 0; m_win = 0; m_lose = 0;
      end
    end else if (running == 1) begin
      if (tc != 0) running = 2;
    end else begin
      counted = gv && (!RC || g <= range_limit(m_md));
      m_bad   = RC && gv && !counted;
      if (counted && m_tries < MAX_T) m_tries = m_tries + 1;
      if (counted && g == m_sec) begin
        m_win = 1; m_hi = 0; m_lo = 0; m_tl = tc; running = 0;
      end else begin
        if (counted) begin
          m_hi = (g < m_sec);
          m_lo = (g > m_sec);
        end
        if ((counted && m_tries == MAX_T) || tc == 0) begin
          m_lose = 1; running = 0;
        end
      end
    end
  endtask

  task automatic check_all(input string p);
    chk({p, "_restart"}, timer_restart, running != 0);
    chk({p, "_busy"},    busy,          running != 0);
    chk({p, "_hint_hi"}, hint_hi,       m_hi);
    chk({p, "_hint_lo"}, hint_lo,       m_lo);
    chk({p, "_win"},     win,           m_win);
    chk({p, "_lose"},    lose,          m_lose);
    chk({p, "_tries"},   tries_used,    m_tries);
    chk({p, "_tleft"},   time_left,     m_tl);
`ifdef GUESS_RANGE_CHECK_EN
    chk({p, "_bad"},     bad_guess,     m_bad);
`endif
  endtask

  // Called at posedge+1; applies inputs, advances one clock, checks at posedge+1.
  task automatic step(input string p, input bit st, input int md, input int sec,
                      input bit gv, input int g);
    start       = st;
    Max_digit   = 2'(md);
    secret      = 7'(sec);
    guess_valid = gv;
    guess       = 7'(g);
    mdl_clock(st, md, sec, gv, g, int'(tcnt));
    @(posedge clk);
    #1;
    start       = 1'b0;
    guess_valid = 1'b0;
    check_all(p);
  endtask

  task automatic idle(input string p);
    step(p, 1'b0, 0, 0, 1'b0, 0);
  endtask

  task automatic wait_play(input string p);
    for (int i = 0; i < 8 && running != 2; i++) idle(p);
    chk({p, "_in_play"}, busy, 1);
  endtask

  int tc_snap;
  bit done;

  initial begin
    rst_n = 1'b0; start = 1'b0; Max_digit = 2'd0; secret = 7'd0;
    guess = 7'd0; guess_valid = 1'b0; tm_load = 7'd60;
    mdl_reset();
    #22 rst_n = 1'b1;
    @(posedge clk); #1;
    check_all("reset");

    // Invalid difficulty is ignored in IDLE
    step("md0", 1'b1, 0, 33, 1'b0, 0);
    chk("md0_restart", timer_restart, 0);
    idle("md0b");

    // Round: hint then win, time_left equals count at the strobe
    tm_load = 7'd60;
    step("t1_start", 1'b1, 1, 5, 1'b0, 0);
    wait_play("t1_wait");
    step("t1_g3", 1'b0, 0, 0, 1'b1, 3);
    chk("t1_hint_hi", hint_hi, 1);
    chk("t1_tries1", tries_used, 1);
    tc_snap = int'(tcnt);
    step("t1_g5", 1'b0, 0, 0, 1'b1, 5);
    chk("t1_win", win, 1);
    chk("t1_tleft", time_left, tc_snap);
    idle("t1_hold");

    // Timeout: no guesses, lose on first zero, no wrap
    tm_load = 7'd30;
    step("t2_start", 1'b1, 1, 50, 1'b0, 0);
    wait_play("t2_wait");
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      idle("t2_run");
      done = lose;
    end
    chk("t2_lose", lose, 1);
    chk("t2_restart", timer_restart, 0);
    idle("t2_after");
    chk("t2_nowrap", timer_count, 0);

    // Tries exhausted: ten guesses too high
    tm_load = 7'd100;
    step("t3_start", 1'b1, 2, 20, 1'b0, 0);
    wait_play("t3_wait");
    for (int i = 0; i < MAX_T; i++) begin
      step("t3_g21", 1'b0, 0, 0, 1'b1, 21);
      chk("t3_hint_lo", hint_lo, 1);
    end
    chk("t3_lose", lose, 1);
    chk("t3_tries", tries_used, MAX_T);

    // Correct guess on the exact cycle the count is zero; start with a
    // simultaneous guess from LOSE
    tm_load = 7'd4;
    step("t4_start", 1'b1, 1, 9, 1'b1, 9);
    wait_play("t4_wait");
    for (int i = 0; i < 10 && tcnt != 7'd0; i++) idle("t4_run");
    chk("t4_at_zero", timer_count, 0);
    step("t4_g9", 1'b0, 0, 0, 1'b1, 9);
    chk("t4_win", win, 1);
    chk("t4_lose", lose, 0);
    chk("t4_tleft", time_left, 0);

    // start during play is ignored while a guess is processed
    tm_load = 7'd50;
    step("t5_start", 1'b1, 3, 70, 1'b0, 0);
    wait_play("t5_wait");
    step("t5_mid", 1'b1, 1, 3, 1'b1, 80);
    chk("t5_tries", tries_used, 1);
    chk("t5_hint_lo", hint_lo, 1);

    // Asynchronous reset mid-round
    #2 rst_n = 1'b0;
    #1;
    mdl_reset();
    check_all("t5_rst");
    chk("t5_rst_restart", timer_restart, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle("t5_post");

`ifdef GUESS_RANGE_CHECK_EN
    tm_load = 7'd60;
    step("t6_start", 1'b1, 1, 5, 1'b0, 0);
    wait_play("t6_wait");
    step("t6_g3", 1'b0, 0, 0, 1'b1, 3);
    step("t6_g12", 1'b0, 0, 0, 1'b1, 12);
    chk("t6_bad", bad_guess, 1);
    chk("t6_tries", tries_used, 1);
    chk("t6_hint_hi", hint_hi, 1);
    idle("t6_after");
    chk("t6_bad_pulse", bad_guess, 0);
`endif

    // Randomized play against the model
    for (int i = 0; i < 600; i++) begin
      bit st, gv;
      int md, sec, g;
      tm_load = 7'($urandom_range(3, 40));
      st  = ($urandom_range(0, 7) == 0);
      md  = $urandom_range(0, 3);
      sec = $urandom_range(0, 15);
      gv  = ($urandom_range(0, 2) == 0);
      g   = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 15);
      step("rnd", st, md, sec, gv, g);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
